// File: rtl/uart_fifo_port.sv
// Port-mapped UART front end: TX/RX FIFOs, status/control registers, RX error capture and a maskable interrupt.
// Optional TX->RX loopback path is built only when UART_PORT_LOOPBACK_EN is defined.

module uart_fifo_port_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rstsb,
    input  logic                  flush,
    input  logic                  push,
    input  logic                  pop,
    input  logic [7:0]            din,
    output logic [7:0]            dout,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  drop
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          pop_ok;
    logic          push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop & ~empty & ~flush;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign push_ok = push & ~flush & (~full | pop_ok);
    assign drop    = push & ~flush & ~push_ok;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rstsb) begin
        if (!rstsb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// state    | meaning
// TX_IDLE  | waiting for data in TX FIFO and tx_rdy
// TX_LOAD  | tx_ld pulse, head byte handed to transmit_engine
// TX_WAIT  | waiting for tx_rdy to drop and return
// RX_IDLE  | waiting for rx_rdy
// RX_ACK   | byte pushed, error flags captured, rx_ack pulsed
// RX_HOLD  | waiting for rx_rdy to drop
module uart_fifo_port #(
    parameter logic [7:0] BASE_ADDR  = 8'h00,
    parameter int         DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rstsb,
    input  logic [7:0] port_id,
    input  logic       write_strobe,
    input  logic       read_strobe,
    input  logic [7:0] out_port,
    output logic [7:0] in_port,
    output logic       interrupt,
    input  logic       interrupt_ack,
    output logic       tx_ld,
    output logic [7:0] tx_data,
    input  logic       tx_rdy,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    input  logic       rx_perr,
    input  logic       rx_ferr,
    output logic       rx_ack
);
    typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_WAIT} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_HOLD} rx_state_t;

`ifdef UART_PORT_LOOPBACK_EN
    localparam logic [3:0] CTRL_MASK = 4'hF;
`else
    localparam logic [3:0] CTRL_MASK = 4'h7;
`endif

    tx_state_t tx_state;
    rx_state_t rx_state;

    logic [7:0]          offset;
    logic                in_win;
    logic                wr_tx;
    logic                wr_ctrl;
    logic                rd_rx;
    logic                flush_rx;
    logic                flush_tx;
    logic                clr_err;

    logic [3:0]          ctrl_q;
    logic                rx_ovf;
    logic                tx_ovf;
    logic                perr;
    logic                ferr;
    logic                irq_pend;
    logic                cond_q;
    logic                irq_cond;
    logic                tx_seen_busy;

    logic [7:0]          tx_head;
    logic [DEPTH_LOG2:0] tx_count;
    logic                tx_fifo_empty;
    logic                tx_fifo_full;
    logic                tx_drop;
    logic                tx_pop;
    logic                tx_start;
    logic                tx_empty;

    logic [7:0]          rx_head;
    logic [7:0]          rx_din;
    logic [DEPTH_LOG2:0] rx_count;
    logic                rx_fifo_empty;
    logic                rx_fifo_full;
    logic                rx_drop;
    logic                rx_push;

    logic                lb_on;
    logic                lb_move;
    logic [7:0]          status;

    // Subtraction wraps, so a window that straddles 8'hFF still decodes correctly.
    assign offset   = port_id - BASE_ADDR;
    assign in_win   = (offset < 8'd5);
    assign wr_tx    = write_strobe & in_win & (offset == 8'd1);
    assign wr_ctrl  = write_strobe & in_win & (offset == 8'd2);
    assign rd_rx    = read_strobe  & in_win & (offset == 8'd1);
    assign flush_rx = wr_ctrl & out_port[4];
    assign flush_tx = wr_ctrl & out_port[5];
    assign clr_err  = wr_ctrl & out_port[6];

`ifdef UART_PORT_LOOPBACK_EN
    assign lb_on   = ctrl_q[3];
    assign lb_move = lb_on & ~tx_fifo_empty & ~rx_fifo_full & (rx_state == RX_IDLE)
                     & ~flush_tx & ~flush_rx;
    assign rx_din  = lb_move ? tx_head : rx_data;
`else
    assign lb_on   = 1'b0;
    assign lb_move = 1'b0;
    assign rx_din  = rx_data;
`endif

    assign tx_start = (tx_state == TX_IDLE) & ~tx_fifo_empty & tx_rdy & ~flush_tx & ~lb_on;
    assign tx_pop   = tx_start | lb_move;
    assign rx_push  = (rx_state == RX_ACK) | lb_move;
    assign tx_empty = tx_fifo_empty & (tx_state == TX_IDLE) & tx_rdy;

    uart_fifo_port_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clk   (clk),
        .rstsb (rstsb),
        .flush (flush_tx),
        .push  (wr_tx),
        .pop   (tx_pop),
        .din   (out_port),
        .dout  (tx_head),
        .count (tx_count),
        .empty (tx_fifo_empty),
        .full  (tx_fifo_full),
        .drop  (tx_drop)
    );

    uart_fifo_port_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clk   (clk),
        .rstsb (rstsb),
        .flush (flush_rx),
        .push  (rx_push),
        .pop   (rd_rx),
        .din   (rx_din),
        .dout  (rx_head),
        .count (rx_count),
        .empty (rx_fifo_empty),
        .full  (rx_fifo_full),
        .drop  (rx_drop)
    );

    assign irq_cond = (~rx_fifo_empty & ctrl_q[0])
                    | (tx_empty & ctrl_q[1])
                    | ((rx_ovf | perr | ferr) & ctrl_q[2]);
    assign interrupt = irq_pend;

    assign status = {irq_pend, ferr, perr, rx_ovf, rx_fifo_full, tx_empty,
                     ~tx_fifo_full, ~rx_fifo_empty};

    always_comb begin
        in_port = 8'h00;
        if (in_win) begin
            case (offset)
                8'd0:    in_port = status;
                8'd1:    in_port = rx_fifo_empty ? 8'h00 : rx_head;
                8'd2:    in_port = {tx_ovf, 3'b000, ctrl_q};
                8'd3:    in_port = 8'(rx_count);
                8'd4:    in_port = 8'(tx_count);
                default: in_port = 8'h00;
            endcase
        end
    end

    // A new event in the same cycle as clr_err stays recorded.
    always_ff @(posedge clk or negedge rstsb) begin
        if (!rstsb) begin
            ctrl_q   <= 4'h0;
            rx_ovf   <= 1'b0;
            tx_ovf   <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            cond_q   <= 1'b0;
            irq_pend <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_q <= out_port[3:0] & CTRL_MASK;
            end
            rx_ovf <= (rx_ovf & ~clr_err) | rx_drop;
            tx_ovf <= (tx_ovf & ~clr_err) | tx_drop;
            perr   <= (perr & ~clr_err) | ((rx_state == RX_ACK) & rx_perr);
            ferr   <= (ferr & ~clr_err) | ((rx_state == RX_ACK) & rx_ferr);
            cond_q <= irq_cond;
            if (irq_cond & ~cond_q) begin
                irq_pend <= 1'b1;
            end else if (interrupt_ack) begin
                irq_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstsb) begin
        if (!rstsb) begin
            tx_state     <= TX_IDLE;
            tx_ld        <= 1'b0;
            tx_data      <= 8'h00;
            tx_seen_busy <= 1'b0;
        end else begin
            tx_ld <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (tx_start) begin
                        tx_state <= TX_LOAD;
                        tx_ld    <= 1'b1;
                        tx_data  <= tx_head;
                    end
                end
                TX_LOAD: begin
                    tx_state     <= TX_WAIT;
                    tx_seen_busy <= ~tx_rdy;
                end
                TX_WAIT: begin
                    if (!tx_rdy) begin
                        tx_seen_busy <= 1'b1;
                    end else if (tx_seen_busy) begin
                        tx_state     <= TX_IDLE;
                        tx_seen_busy <= 1'b0;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstsb) begin
        if (!rstsb) begin
            rx_state <= RX_IDLE;
            rx_ack   <= 1'b0;
        end else begin
            rx_ack <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_rdy && !lb_on) begin
                        rx_state <= RX_ACK;
                        rx_ack   <= 1'b1;
                    end
                end
                RX_ACK:  rx_state <= RX_HOLD;
                RX_HOLD: begin
                    if (!rx_rdy) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_fifo_port.sv
// Directed bench for uart_fifo_port (BASE_ADDR=8'h10, DEPTH_LOG2=2).
module tb_uart_fifo_port;
    localparam logic [7:0] BASE = 8'h10;

    logic       clk;
    logic       rstsb;
    logic [7:0] port_id;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] out_port;
    logic [7:0] in_port;
    logic       interrupt;
    logic       interrupt_ack;
    logic       tx_ld;
    logic [7:0] tx_data;
    logic       tx_rdy;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       rx_perr;
    logic       rx_ferr;
    logic       rx_ack;

    int n_cmp = 0;
    int n_err = 0;
    int n_tx_ld = 0;
    int n_rx_ack = 0;

    uart_fifo_port #(.BASE_ADDR(BASE), .DEPTH_LOG2(2)) dut (
        .clk           (clk),
        .rstsb         (rstsb),
        .port_id       (port_id),
        .write_strobe  (write_strobe),
        .read_strobe   (read_strobe),
        .out_port      (out_port),
        .in_port       (in_port),
        .interrupt     (interrupt),
        .interrupt_ack (interrupt_ack),
        .tx_ld         (tx_ld),
        .tx_data       (tx_data),
        .tx_rdy        (tx_rdy),
        .rx_rdy        (rx_rdy),
        .rx_data       (rx_data),
        .rx_perr       (rx_perr),
        .rx_ferr       (rx_ferr),
        .rx_ack        (rx_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_ld)  n_tx_ld++;
        if (rx_ack) n_rx_ack++;
    end

    task automatic cpu_read(input logic [7:0] off, output logic [7:0] d);
        @(negedge clk);
        port_id     = BASE + off;
        read_strobe = 1'b1;
        #1 d = in_port;
        @(posedge clk);
        #1 read_strobe = 1'b0;
        port_id = 8'h00;
    endtask

    task automatic cpu_write(input logic [7:0] off, input logic [7:0] d);
        @(negedge clk);
        port_id      = BASE + off;
        out_port     = d;
        write_strobe = 1'b1;
        @(posedge clk);
        #1 write_strobe = 1'b0;
        port_id = 8'h00;
    endtask

    task automatic rx_send(input logic [7:0] d, input logic pe, input logic fe, input logic ack_irq);
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        rx_data = d; rx_perr = pe; rx_ferr = fe; rx_rdy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rx_ack) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL rx_ack_timeout byte %02h: rx_ack got 0 want 1", d);
        end
        @(negedge clk);
        rx_rdy = 1'b0; rx_perr = 1'b0; rx_ferr = 1'b0;
        if (ack_irq) interrupt_ack = 1'b1;
        @(negedge clk);
        interrupt_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [7:0] d;
        logic [7:0] exp_r [5];
        exp_r[0] = 8'h06; exp_r[1] = 8'h00; exp_r[2] = 8'h00; exp_r[3] = 8'h00; exp_r[4] = 8'h00;
        for (int i = 0; i < 5; i++) begin
            cpu_read(8'(i), d);
            n_cmp++;
            if (d !== exp_r[i]) begin
                n_err++;
                $display("FAIL reset_reg%0d: got %02h want %02h", i, d, exp_r[i]);
            end
        end
        cpu_read(8'd5, d);
        n_cmp++;
        if (d !== 8'h00) begin n_err++; $display("FAIL out_of_window: got %02h want 00", d); end
        n_cmp++;
        if (interrupt !== 1'b0 || tx_ld !== 1'b0 || rx_ack !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: irq=%b tx_ld=%b rx_ack=%b want 0 0 0", interrupt, tx_ld, rx_ack);
        end
    endtask

    task automatic test_tx_sequence;
        logic [7:0] d;
        logic [7:0] bytes [3];
        logic       seen;
        int         ld0;
        bytes[0] = 8'h41; bytes[1] = 8'h42; bytes[2] = 8'h43;
        ld0 = n_tx_ld;
        tx_rdy = 1'b0;
        for (int i = 0; i < 3; i++) cpu_write(8'd1, bytes[i]);
        cpu_read(8'd4, d);
        n_cmp++;
        if (d !== 8'h03) begin n_err++; $display("FAIL tx_count_full: got %02h want 03", d); end
        @(negedge clk);
        tx_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            seen = 1'b0;
            for (int k = 0; k < 30; k++) begin
                if (tx_ld) begin seen = 1'b1; break; end
                @(negedge clk);
            end
            n_cmp++;
            if (!seen || tx_data !== bytes[i]) begin
                n_err++;
                $display("FAIL tx_byte%0d: seen=%b tx_data got %02h want %02h", i, seen, tx_data, bytes[i]);
            end
            tx_rdy = 1'b0;
            cpu_read(8'd4, d);
            n_cmp++;
            if (d !== 8'(2 - i)) begin n_err++; $display("FAIL tx_count_after%0d: got %02h want %02h", i, d, 8'(2 - i)); end
            if (i == 0) begin
                cpu_read(8'd0, d);
                n_cmp++;
                if (d !== 8'h02) begin n_err++; $display("FAIL tx_busy_status: got %02h want 02", d); end
            end
            repeat (8) @(negedge clk);
            tx_rdy = 1'b1;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        cpu_read(8'd0, d);
        n_cmp++;
        if (d !== 8'h06) begin n_err++; $display("FAIL tx_done_status: got %02h want 06", d); end
        n_cmp++;
        if (n_tx_ld - ld0 !== 3) begin n_err++; $display("FAIL tx_ld_count: got %0d want 3", n_tx_ld - ld0); end
    endtask

    task automatic test_rx_overflow;
        logic [7:0] d;
        int a0;
        a0 = n_rx_ack;
        for (int i = 0; i < 5; i++) rx_send(8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (n_rx_ack - a0 !== 5) begin n_err++; $display("FAIL rx_ack_count: got %0d want 5", n_rx_ack - a0); end
        cpu_read(8'd3, d);
        n_cmp++;
        if (d !== 8'h04) begin n_err++; $display("FAIL rx_count_full: got %02h want 04", d); end
        cpu_read(8'd0, d);
        n_cmp++;
        if (d !== 8'h1F) begin n_err++; $display("FAIL rx_ovf_status: got %02h want 1f", d); end
        for (int i = 0; i < 5; i++) begin
            cpu_read(8'd1, d);
            n_cmp++;
            if (d !== ((i < 4) ? 8'h10 + 8'(i) : 8'h00)) begin
                n_err++;
                $display("FAIL rx_pop%0d: got %02h want %02h", i, d, (i < 4) ? 8'h10 + 8'(i) : 8'h00);
            end
        end
        cpu_write(8'd2, 8'h40);
        cpu_read(8'd0, d);
        n_cmp++;
        if (d !== 8'h06) begin n_err++; $display("FAIL rx_ovf_clear: got %02h want 06", d); end
    endtask

    task automatic test_rx_errors;
        logic [7:0] d;
        rx_send(8'h55, 1'b1, 1'b0, 1'b0);
        cpu_read(8'd0, d);
        n_cmp++;
        if (d !== 8'h27) begin n_err++; $display("FAIL perr_status: got %02h want 27", d); end
        cpu_read(8'd1, d);
        n_cmp++;
        if (d !== 8'h55) begin n_err++; $display("FAIL perr_byte: got %02h want 55", d); end
        cpu_write(8'd2, 8'h40);
        cpu_read(8'd0, d);
        n_cmp++;
        if (d !== 8'h06) begin n_err++; $display("FAIL perr_clear: got %02h want 06", d); end
        cpu_write(8'd2, 8'h04);
        rx_send(8'h66, 1'b0, 1'b1, 1'b0);
        cpu_read(8'd0, d);
        n_cmp++;
        if (d !== 8'hC7 || interrupt !== 1'b1) begin
            n_err++;
            $display("FAIL err_irq: status got %02h want c7, interrupt got %b want 1", d, interrupt);
        end
        @(negedge clk); interrupt_ack = 1'b1;
        @(negedge clk); interrupt_ack = 1'b0;
        #1;
        n_cmp++;
        if (interrupt !== 1'b0) begin n_err++; $display("FAIL err_irq_ack: got %b want 0", interrupt); end
        cpu_write(8'd2, 8'h40);
        cpu_read(8'd1, d);
        n_cmp++;
        if (d !== 8'h66) begin n_err++; $display("FAIL ferr_byte: got %02h want 66", d); end
    endtask

    task automatic test_irq_ack_race;
        logic [7:0] d;
        cpu_write(8'd2, 8'h02);
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (interrupt !== 1'b1) begin n_err++; $display("FAIL tx_irq: got %b want 1", interrupt); end
        cpu_write(8'd2, 8'h01);
        rx_send(8'h21, 1'b0, 1'b0, 1'b1);
        #1;
        n_cmp++;
        if (interrupt !== 1'b1) begin n_err++; $display("FAIL irq_ack_race: got %b want 1", interrupt); end
        @(negedge clk); interrupt_ack = 1'b1;
        @(negedge clk); interrupt_ack = 1'b0;
        #1;
        n_cmp++;
        if (interrupt !== 1'b0) begin n_err++; $display("FAIL irq_plain_ack: got %b want 0", interrupt); end
        cpu_read(8'd1, d);
        n_cmp++;
        if (d !== 8'h21) begin n_err++; $display("FAIL race_byte: got %02h want 21", d); end
        cpu_write(8'd2, 8'h00);
    endtask

    task automatic test_flush;
        logic [7:0] d;
        int ld0;
        ld0 = n_tx_ld;
        tx_rdy = 1'b0;
        cpu_write(8'd1, 8'hAA);
        cpu_write(8'd1, 8'hBB);
        rx_send(8'h31, 1'b0, 1'b0, 1'b0);
        rx_send(8'h32, 1'b0, 1'b0, 1'b0);
        cpu_write(8'd2, 8'h30);
        cpu_read(8'd4, d);
        n_cmp++;
        if (d !== 8'h00) begin n_err++; $display("FAIL flush_tx_count: got %02h want 00", d); end
        cpu_read(8'd3, d);
        n_cmp++;
        if (d !== 8'h00) begin n_err++; $display("FAIL flush_rx_count: got %02h want 00", d); end
        cpu_read(8'd2, d);
        n_cmp++;
        if (d !== 8'h00) begin n_err++; $display("FAIL flush_selfclear: got %02h want 00", d); end
        tx_rdy = 1'b1;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (n_tx_ld !== ld0) begin n_err++; $display("FAIL flush_no_tx_ld: got %0d want %0d", n_tx_ld, ld0); end
    endtask

    task automatic test_loopback;
        logic [7:0] d;
        int ld0;
        ld0 = n_tx_ld;
`ifdef UART_PORT_LOOPBACK_EN
        cpu_write(8'd2, 8'h08);
        cpu_write(8'd1, 8'h5A);
        cpu_write(8'd1, 8'hA5);
        repeat (3) @(negedge clk);
        cpu_read(8'd1, d);
        n_cmp++;
        if (d !== 8'h5A) begin n_err++; $display("FAIL loopback_b0: got %02h want 5a", d); end
        cpu_read(8'd1, d);
        n_cmp++;
        if (d !== 8'hA5) begin n_err++; $display("FAIL loopback_b1: got %02h want a5", d); end
        n_cmp++;
        if (n_tx_ld !== ld0) begin n_err++; $display("FAIL loopback_tx_ld: got %0d want %0d", n_tx_ld, ld0); end
        cpu_write(8'd2, 8'h00);
`else
        cpu_write(8'd2, 8'h08);
        cpu_read(8'd2, d);
        n_cmp++;
        if (d !== 8'h00) begin n_err++; $display("FAIL ctrl_bit3_ro: got %02h want 00", d); end
        n_cmp++;
        if (n_tx_ld !== ld0) begin n_err++; $display("FAIL ctrl_bit3_tx_ld: got %0d want %0d", n_tx_ld, ld0); end
`endif
    endtask

    task automatic test_reset_mid_tx;
        logic [7:0] d;
        logic seen;
        seen = 1'b0;
        tx_rdy = 1'b0;
        cpu_write(8'd1, 8'h77);
        @(negedge clk);
        tx_rdy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (tx_ld) begin seen = 1'b1; break; end
        end
        #1 rstsb = 1'b0;
        #1;
        n_cmp++;
        if (!seen || tx_ld !== 1'b0) begin
            n_err++;
            $display("FAIL reset_cuts_tx_ld: seen=%b tx_ld got %b want 0", seen, tx_ld);
        end
        @(negedge clk);
        rstsb = 1'b1;
        cpu_read(8'd0, d);
        n_cmp++;
        if (d !== 8'h06) begin n_err++; $display("FAIL reset_mid_status: got %02h want 06", d); end
        cpu_read(8'd4, d);
        n_cmp++;
        if (d !== 8'h00) begin n_err++; $display("FAIL reset_mid_tx_count: got %02h want 00", d); end
    endtask

    initial begin
        rstsb = 1'b0; port_id = 8'h00; write_strobe = 1'b0; read_strobe = 1'b0;
        out_port = 8'h00; interrupt_ack = 1'b0; tx_rdy = 1'b1; rx_rdy = 1'b0;
        rx_data = 8'h00; rx_perr = 1'b0; rx_ferr = 1'b0;
        repeat (3) @(negedge clk);
        rstsb = 1'b1;
        test_reset();
        test_tx_sequence();
        test_rx_overflow();
        test_rx_errors();
        test_irq_ack_race();
        test_flush();
        test_loopback();
        test_reset_mid_tx();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
